spi_flash_arbiter: RTL and testbench
====================================

Name: spi_flash_arbiter

Overview:
Shares the single configuration SPI flash between two requesters: port 0 is the DFU core's SPI master, and port 1 is an auxiliary master such as a user-image readback or boot-config reader. Each requester drives its own csel/sclk/mosi. The arbiter grants one requester at a time on a whole-transaction basis, with round-robin fairness. It enforces a minimum chip-select deselect gap between owners and registers the pins driven onto the flash (sclk goes through USRMCLK at top level).

Parameters:
CS_GAP_CYCLES, 4, minimum clk cycles flash_csel held high between two grants; legal range 1..255.
TIMEOUT_CYCLES, 24'd12000000, maximum grant length in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
clk  in  1  system clock (12 MHz domain)
resetn  in  1  synchronous, active-low reset
req  in  2  per-port request; bit n = port n
gnt  out  2  per-port grant, one-hot or zero, registered
req_csel  in  2  per-port chip select, active-low
req_sclk  in  2  per-port serial clock
req_mosi  in  2  per-port MOSI
req_miso  out  2  per-port MISO return
flash_csel  out  1  to flash, active-low, registered
flash_sclk  out  1  to flash (via USRMCLK), registered
flash_mosi  out  1  to flash, registered
flash_miso  in  1  from flash
busy  out  1  high in any state other than IDLE
timeout  out  1  one-cycle pulse on forced revoke

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low (resetn sampled on posedge clk).
- Reset values: gnt=00, flash_csel=1, flash_sclk=0, flash_mosi=0, busy=0, timeout=0, state=IDLE, rr_ptr=0, gap counter=0.
- Reset mid-transaction: at the next edge all outputs take their reset values regardless of state. flash_csel rises immediately; no gap is enforced.
- IDLE:
  - Outputs are idle levels.
  - If exactly one req bit is high, grant that port.
  - If both are high, grant port rr_ptr.
  - Transition to GRANT0/GRANT1; gnt[n] goes high on the edge after req is sampled (1-cycle latency).
  - On grant, rr_ptr <= ~n.
- GRANTn:
  - flash_csel/sclk/mosi <= req_csel[n]/req_sclk[n]/req_mosi[n] (1-cycle registered delay).
  - req_miso[n] = flash_miso combinationally; the non-granted port's req_miso = 0.
  - When req[n] is sampled low: go to GAP, gnt <= 00, flash_csel <= 1, flash_sclk <= 0, flash_mosi <= 0, gap counter <= CS_GAP_CYCLES-1.
  - The requester must raise its csel before dropping req. The arbiter forces csel high on exit regardless.
- GAP:
  - flash_csel held 1, gnt=00, busy=1.
  - Counter decrements each cycle. When counter==0, go to IDLE.
  - This yields exactly CS_GAP_CYCLES cycles of csel high before the IDLE cycle, with the next grant one cycle after that.
- Requests withdrawn before grant are dropped silently; no grant is issued.
- Requester pins are ignored whenever that port is not granted.
- A req toggle from the other port while one port is granted has no effect until IDLE.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined:
  - A grant-length counter clears on entering GRANTn and increments each GRANT cycle.
  - When it reaches TIMEOUT_CYCLES-1 while req[n] is still high: go to GAP as on a normal release, and pulse timeout for 1 cycle.
  - Port n is blocked from re-grant until req[n] has been sampled low at least once (per-port rearm flag).
- Undefined: no counter; timeout is tied to 0; the TIMEOUT_CYCLES parameter is ignored.

Decomposition:
- Package spi_arb_pkg holds:
  - state encoding (IDLE, GRANT0, GRANT1, GAP);
  - port index constants PORT_DFU=0, PORT_AUX=1;
  - counter widths (GAP_W=8, TMO_W=24).
- One sub-module, spi_arb_downcounter, is natural: a loadable down-counter with a zero flag, instanced for the gap and, under the macro, for the timeout (loaded with TIMEOUT_CYCLES-1).

Test Plan:
1. Hold resetn=0 for 2 cycles with random req/pins -> gnt=00, flash_csel=1, flash_sclk=0, flash_mosi=0, busy=0, timeout=0.
2. req=01 at cycle 10 -> gnt=01 at cycle 11. Drive csel0=0 and toggle sclk0 -> flash pins follow 1 cycle later. flash_miso=1 -> req_miso=01. req_sclk[1] toggling -> no effect on flash_sclk.
3. After reset, req=11 -> gnt=01. Release req0 -> flash_csel high for exactly 4 cycles, then gnt=10. Release, then req=11 again -> gnt=01 (round-robin).
4. Port 0 drops req and re-raises it the next cycle -> gnt[0] re-asserts no earlier than 5 cycles after the drop. flash_csel stays 1 throughout the gap.
5. During GRANT1 with csel1=0, pulse resetn=0 for 1 cycle -> flash_csel=1 and gnt=00 next edge. A subsequent req=11 grants port 0 (rr_ptr reset).
6. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, port 1 holds req -> gnt[1] falls after 16 grant cycles, timeout pulses 1 cycle, then the gap. Pending req0 -> gnt=01. Port 1 is not re-granted until req1 has been sampled low.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI flash arbiter
//
// Purpose : FSM state encoding, requester port indices and counter widths
//           used by spi_flash_arbiter and spi_arb_downcounter.
// Ports   : none (package).
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int PORT_DFU = 0;
  localparam int PORT_AUX = 1;

  localparam int GAP_W = 8;
  localparam int TMO_W = 24;

endpackage

// File: rtl/spi_arb_downcounter.sv
// rtl/spi_arb_downcounter.sv - loadable down-counter with zero flag
//
// Purpose : Load a start value, count down by one per enabled cycle and
//           hold at zero. Used for the chip-select gap and grant timeout.
// Ports   : clk, resetn   - clock, synchronous active-low reset
//           i_load        - load i_load_val (wins over i_dec)
//           i_load_val    - value to load
//           i_dec         - decrement enable (saturates at zero)
//           o_zero        - count is zero
module spi_arb_downcounter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-port round-robin arbiter for one SPI flash
//
// Purpose : Grants the flash to one requester per whole transaction with
//           round-robin fairness, enforces a minimum csel-high gap between
//           owners and registers the pins driven to the flash.
// Ports   : clk, resetn            - clock, synchronous active-low reset
//           req[1:0], gnt[1:0]     - per-port request / registered grant
//           req_csel/sclk/mosi     - per-port SPI pins from requesters
//           req_miso[1:0]          - flash MISO routed to granted port only
//           flash_csel/sclk/mosi   - registered pins to the flash
//           flash_miso             - MISO from the flash
//           busy                   - not in IDLE
//           timeout                - one-cycle pulse on forced revoke
// Macro   : SPI_ARB_TIMEOUT_EN enables the grant-length limit and per-port
//           rearm; when undefined timeout is 0 and TIMEOUT_CYCLES is unused.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int               CS_GAP_CYCLES  = 4,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd12000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] req_csel,
  input  logic [1:0] req_sclk,
  input  logic [1:0] req_mosi,
  output logic [1:0] req_miso,
  output logic       flash_csel,
  output logic       flash_sclk,
  output logic       flash_mosi,
  input  logic       flash_miso,
  output logic       busy,
  output logic       timeout
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_gnt;
  logic       r_csel;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_rr;
  logic       r_timeout;

  logic       w_in_grant;
  logic       w_idx;
  logic [1:0] w_req_eff;
  logic       w_tmo_hit;
  logic       w_release;
  logic       w_grant_start;
  logic       w_pick;
  logic       w_gap_zero;

  assign w_in_grant    = (r_state == GRANT0) || (r_state == GRANT1);
  assign w_idx         = (r_state == GRANT1);
  assign w_grant_start = (r_state == IDLE) && (w_req_eff != 2'b00);
  // Contention goes to the round-robin pointer; otherwise the lone requester.
  assign w_pick        = (w_req_eff == 2'b11) ? r_rr : w_req_eff[PORT_AUX];
  assign w_release     = w_in_grant && (!req[w_idx] || w_tmo_hit);

`ifdef SPI_ARB_TIMEOUT_EN
  logic [1:0] r_blocked;
  logic       w_tmo_zero;

  // A port revoked by timeout stays blocked until its req is seen low.
  assign w_req_eff = req & ~r_blocked;
  assign w_tmo_hit = w_in_grant && w_tmo_zero && req[w_idx];

  spi_arb_downcounter #(.W(TMO_W)) u_tmo_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_grant_start),
    .i_load_val (TIMEOUT_CYCLES - 1'b1),
    .i_dec      (w_in_grant),
    .o_zero     (w_tmo_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_blocked <= 2'b00;
    end else begin
      r_blocked <= (r_blocked & req) |
                   (w_tmo_hit ? (w_idx ? 2'b10 : 2'b01) : 2'b00);
    end
  end
`else
  logic w_unused_tmo;

  assign w_req_eff    = req;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  spi_arb_downcounter #(.W(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_release),
    .i_load_val (GAP_LOAD),
    .i_dec      (r_state == GAP),
    .o_zero     (w_gap_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_gnt     <= 2'b00;
      r_csel    <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_rr      <= PORT_DFU[0];
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_hit;
      case (r_state)
        IDLE: begin
          if (w_grant_start) begin
            r_state <= w_pick ? GRANT1 : GRANT0;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_rr    <= ~w_pick;
          end
        end
        GRANT0, GRANT1: begin
          if (w_release) begin
            // csel is forced high here even if the requester left it low.
            r_state <= GAP;
            r_gnt   <= 2'b00;
            r_csel  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
          end else begin
            r_csel  <= req_csel[w_idx];
            r_sclk  <= req_sclk[w_idx];
            r_mosi  <= req_mosi[w_idx];
          end
        end
        GAP: begin
          if (w_gap_zero) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign flash_csel = r_csel;
  assign flash_sclk = r_sclk;
  assign flash_mosi = r_mosi;
  assign busy       = (r_state != IDLE);
  assign timeout    = r_timeout;
  assign req_miso   = {(r_state == GRANT1) & flash_miso,
                       (r_state == GRANT0) & flash_miso};

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

  logic       clk;
  logic       resetn;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] req_csel;
  logic [1:0] req_sclk;
  logic [1:0] req_mosi;
  logic [1:0] req_miso;
  logic       flash_csel;
  logic       flash_sclk;
  logic       flash_mosi;
  logic       flash_miso;
  logic       busy;
  logic       timeout;

  int vectors;
  int miscompares;

  spi_flash_arbiter #(
    .CS_GAP_CYCLES  (4),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .gnt        (gnt),
    .req_csel   (req_csel),
    .req_sclk   (req_sclk),
    .req_mosi   (req_mosi),
    .req_miso   (req_miso),
    .flash_csel (flash_csel),
    .flash_sclk (flash_sclk),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    req      = 2'b00;
    req_csel = 2'b11;
    req_sclk = 2'b00;
    req_mosi = 2'b00;
    flash_miso = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    req        = 2'($urandom_range(0, 3));
    req_csel   = 2'($urandom_range(0, 3));
    req_sclk   = 2'($urandom_range(0, 3));
    req_mosi   = 2'($urandom_range(0, 3));
    flash_miso = 1'($urandom_range(0, 1));
    tick(2);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    vectors++; if (flash_csel !== 1'b1) begin miscompares++; $display("FAIL reset_csel got=%b exp=1", flash_csel); end
    vectors++; if (flash_sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk got=%b exp=0", flash_sclk); end
    vectors++; if (flash_mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi got=%b exp=0", flash_mosi); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
  endtask

  task automatic test_single_grant();
    do_reset();
    tick(8);
    req = 2'b01;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL sg_pre_gnt got=%b exp=00", gnt); end
    tick(1);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL sg_gnt got=%b exp=01", gnt); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sg_busy got=%b exp=1", busy); end
    req_csel = 2'b10; req_sclk = 2'b01; req_mosi = 2'b01;
    tick(1);
    vectors++; if ({flash_csel, flash_sclk, flash_mosi} !== 3'b011) begin
      miscompares++; $display("FAIL sg_pins got=%b exp=011", {flash_csel, flash_sclk, flash_mosi}); end
    flash_miso = 1'b1;
    #1;
    vectors++; if (req_miso !== 2'b01) begin miscompares++; $display("FAIL sg_miso got=%b exp=01", req_miso); end
    // Port 1 pins must not leak through.
    req_sclk = 2'b10; req_mosi = 2'b10;
    tick(1);
    vectors++; if ({flash_sclk, flash_mosi} !== 2'b00) begin
      miscompares++; $display("FAIL sg_isolate got=%b exp=00", {flash_sclk, flash_mosi}); end
    req_csel = 2'b11; req_sclk = 2'b00; req_mosi = 2'b00; flash_miso = 1'b0;
    tick(1);
    req = 2'b00;
    tick(1);
    vectors++; if ({gnt, busy, flash_csel} !== 4'b0011) begin
      miscompares++; $display("FAIL sg_release got=%b exp=0011", {gnt, busy, flash_csel}); end
    tick(3);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sg_gap_busy got=%b exp=1", busy); end
    tick(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sg_idle got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int n;
    bit csel_ok;
    do_reset();
    req = 2'b11;
    tick(1);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL rr_first got=%b exp=01", gnt); end
    req = 2'b10;
    tick(1);
    n = 0; csel_ok = 1'b1;
    while (gnt !== 2'b10 && n < 20) begin
      if (flash_csel !== 1'b1) csel_ok = 1'b0;
      tick(1); n++;
    end
    vectors++; if (n != 5) begin miscompares++; $display("FAIL rr_handover got=%0d exp=5", n); end
    vectors++; if (!csel_ok) begin miscompares++; $display("FAIL rr_gap_csel got=0 exp=1"); end
    req = 2'b00;
    tick(1);
    req = 2'b11;
    n = 0;
    while (gnt !== 2'b01 && n < 20) begin tick(1); n++; end
    vectors++; if (n != 5) begin miscompares++; $display("FAIL rr_back got=%0d exp=5", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit csel_ok;
    req = 2'b00;
    tick(1);
    req = 2'b01;
    n = 0; csel_ok = 1'b1;
    while (gnt !== 2'b01 && n < 20) begin
      if (flash_csel !== 1'b1) csel_ok = 1'b0;
      tick(1); n++;
    end
    vectors++; if (n != 5) begin miscompares++; $display("FAIL b2b_regrant got=%0d exp=5", n); end
    vectors++; if (!csel_ok) begin miscompares++; $display("FAIL b2b_csel got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b10;
    tick(1);
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL rm_gnt got=%b exp=10", gnt); end
    req_csel = 2'b01;
    tick(1);
    vectors++; if (flash_csel !== 1'b0) begin miscompares++; $display("FAIL rm_csel_low got=%b exp=0", flash_csel); end
    resetn = 1'b0;
    tick(1);
    vectors++; if ({flash_csel, gnt, busy} !== 4'b1000) begin
      miscompares++; $display("FAIL rm_reset got=%b exp=1000", {flash_csel, gnt, busy}); end
    resetn = 1'b1; req_csel = 2'b11; req = 2'b11;
    tick(1);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL rm_rr_reset got=%b exp=01", gnt); end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    req = 2'b10;
    tick(1);
    req = 2'b11;
    n = 0;
    while (gnt === 2'b10 && n < 40) begin tick(1); n++; end
    vectors++; if (n != 16) begin miscompares++; $display("FAIL to_len got=%0d exp=16", n); end
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_pulse got=%b exp=1", timeout); end
    tick(1);
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL to_pulse_end got=%b exp=0", timeout); end
    n = 1;
    while (gnt !== 2'b01 && n < 20) begin tick(1); n++; end
    vectors++; if (n != 5) begin miscompares++; $display("FAIL to_pending got=%0d exp=5", n); end
    req = 2'b10;
    tick(10);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL to_blocked got=%b exp=00", gnt); end
    req = 2'b00;
    tick(1);
    req = 2'b10;
    n = 0;
    while (gnt !== 2'b10 && n < 20) begin tick(1); n++; end
    vectors++; if (n != 1) begin miscompares++; $display("FAIL to_rearm got=%0d exp=1", n); end
  endtask
`else
  task automatic test_timeout();
    bit held;
    do_reset();
    req = 2'b10;
    tick(1);
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (gnt !== 2'b10 || timeout !== 1'b0) held = 1'b0;
      tick(1);
    end
    vectors++; if (!held) begin miscompares++; $display("FAIL to_disabled got=0 exp=1"); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    resetn = 1'b0; req = 2'b00; req_csel = 2'b11; req_sclk = 2'b00;
    req_mosi = 2'b00; flash_miso = 1'b0;
    #1;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
